// File: rtl/blk_mem_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : blk_mem_gen                                                  |
// | Description : Asymmetric simple-dual-port synchronous RAM. Narrow write    |
// |               port A (WIDTH_A bits) and wide read port B (WIDTH_A*RATIO    |
// |               bits, little-endian packing), one clock domain, read-first  |
// |               on same-edge collisions.                                     |
// |               Optional macro BLK_MEM_GEN_OUT_REG_EN adds a second port-B   |
// |               output register (read latency 2 instead of 1).             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module blk_mem_gen #(
  parameter int WIDTH_A = 16,
  parameter int DEPTH_A = 4,
  parameter int RATIO   = 2,
  localparam int RATIO_LOG2 = $clog2(RATIO),
  localparam int ADDRA_W    = (DEPTH_A > 1) ? $clog2(DEPTH_A) : 1,
  localparam int ADDRB_W    = ((ADDRA_W - RATIO_LOG2) >= 1) ? (ADDRA_W - RATIO_LOG2) : 1,
  localparam int WIDTH_B    = WIDTH_A * RATIO
) (
  input  logic               clka,
  input  logic               clkb,
  input  logic               rsta,
  input  logic               ena,
  input  logic               wea,
  input  logic [ADDRA_W-1:0] addra,
  input  logic [WIDTH_A-1:0] dina,
  input  logic               enb,
  input  logic [ADDRB_W-1:0] addrb,
  output logic [WIDTH_B-1:0] doutb
);

  // Index width with one spare bit so out-of-range read words can be detected.
  localparam int IDX_W = ADDRB_W + RATIO_LOG2 + 1;

  // clkb exists only for port compatibility; everything runs on clka.
  logic unused_clkb;
  assign unused_clkb = clkb;

  // Storage, zero at configuration; reset deliberately does not touch it.
  logic [WIDTH_A-1:0] mem [DEPTH_A] = '{default: '0};

  logic [WIDTH_B-1:0] rd_word;
  logic [WIDTH_B-1:0] dout_s1;
  logic               wr_in_range;

  assign wr_in_range = ({1'b0, addra} < (ADDRA_W + 1)'(DEPTH_A));

  // Port A write; only a definite ena=1/wea=1 writes, out-of-range words are dropped.
  always_ff @(posedge clka) begin
    if (ena && wea && wr_in_range) begin
      mem[addra] <= dina;
    end
  end

  // Gather RATIO consecutive narrow words into the wide read word, lowest word in the LSBs.
  for (genvar k = 0; k < RATIO; k++) begin : g_pack
    logic [IDX_W-1:0] idx;
    assign idx = IDX_W'(addrb) * IDX_W'(RATIO) + IDX_W'(k);
    assign rd_word[k*WIDTH_A +: WIDTH_A] =
      (idx < IDX_W'(DEPTH_A)) ? mem[idx[ADDRA_W-1:0]] : '0;
  end

  // First output stage: sampled pre-write contents give read-first collision behaviour.
  always_ff @(posedge clka) begin
    if (rsta) begin
      dout_s1 <= '0;
    end else if (enb) begin
      dout_s1 <= rd_word;
    end
  end

`ifdef BLK_MEM_GEN_OUT_REG_EN
  logic [WIDTH_B-1:0] dout_s2;

  // Second output stage advances together with the read enable.
  always_ff @(posedge clka) begin
    if (rsta) begin
      dout_s2 <= '0;
    end else if (enb) begin
      dout_s2 <= dout_s1;
    end
  end

  assign doutb = dout_s2;
`else
  assign doutb = dout_s1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blk_mem_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_blk_mem_gen                                               |
// | Description : Scoreboard bench for blk_mem_gen: directed scenarios plus    |
// |               randomized traffic against a behavioural memory model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_blk_mem_gen;

  localparam int WIDTH_A = 16;
  localparam int DEPTH_A = 4;
  localparam int RATIO   = 2;
  localparam int ADDRA_W = 2;
  localparam int ADDRB_W = 1;
  localparam int WIDTH_B = WIDTH_A * RATIO;

  logic               clka = 1'b0;
  logic               rsta = 1'b0;
  logic               ena  = 1'b0;
  logic               wea  = 1'b0;
  logic [ADDRA_W-1:0] addra = '0;
  logic [WIDTH_A-1:0] dina  = '0;
  logic               enb  = 1'b0;
  logic [ADDRB_W-1:0] addrb = '0;
  logic [WIDTH_B-1:0] doutb;

  always #5 clka = ~clka;

  blk_mem_gen #(
    .WIDTH_A(WIDTH_A),
    .DEPTH_A(DEPTH_A),
    .RATIO  (RATIO)
  ) dut (
    .clka (clka),
    .clkb (clka),
    .rsta (rsta),
    .ena  (ena),
    .wea  (wea),
    .addra(addra),
    .dina (dina),
    .enb  (enb),
    .addrb(addrb),
    .doutb(doutb)
  );

  // Reference model: plain array of narrow words plus the visible output value(s).
  logic [WIDTH_A-1:0] model_mem [DEPTH_A];
  logic [WIDTH_B-1:0] model_s1;
  logic [WIDTH_B-1:0] model_s2;

  logic [WIDTH_B-1:0] exp_q [$];
  string              tag_q [$];
  string              phase;

  int checks = 0;
  int errors = 0;

  // One clock cycle of stimulus; the expected doutb after the edge is queued.
  task automatic cycle(input logic a_en, input logic a_we, input int a_addr,
                       input logic [WIDTH_A-1:0] a_din, input logic b_en,
                       input int b_addr, input logic rst);
    logic [WIDTH_B-1:0] rd;
    logic [WIDTH_B-1:0] exp_out;
    @(negedge clka);
    ena   = a_en;
    wea   = a_we;
    addra = ADDRA_W'(a_addr);
    dina  = a_din;
    enb   = b_en;
    addrb = ADDRB_W'(b_addr);
    rsta  = rst;
    // Read-first: the wide word is built from the contents before this edge's write.
    rd = '0;
    for (int k = 0; k < RATIO; k++) begin
      int w;
      w = b_addr * RATIO + k;
      if (w < DEPTH_A) rd[k*WIDTH_A +: WIDTH_A] = model_mem[w];
    end
`ifdef BLK_MEM_GEN_OUT_REG_EN
    if (rst) model_s2 = '0;
    else if (b_en) model_s2 = model_s1;
`endif
    if (rst) model_s1 = '0;
    else if (b_en) model_s1 = rd;
`ifdef BLK_MEM_GEN_OUT_REG_EN
    exp_out = model_s2;
`else
    exp_out = model_s1;
`endif
    if (a_en && a_we && a_addr < DEPTH_A) model_mem[a_addr] = a_din;
    exp_q.push_back(exp_out);
    tag_q.push_back(phase);
    @(posedge clka);
  endtask

  task automatic wr(input int a, input logic [WIDTH_A-1:0] d);
    cycle(1'b1, 1'b1, a, d, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int b);
    cycle(1'b0, 1'b0, 0, '0, 1'b1, b, 1'b0);
  endtask

  // Monitor: one expected output per clock edge, compared just after the edge.
  initial begin
    logic [WIDTH_B-1:0] e;
    string t;
    forever begin
      @(posedge clka);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (doutb !== e) begin
          errors++;
          $display("FAIL %s: doutb=%h expected %h", t, doutb, e);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    for (int i = 0; i < DEPTH_A; i++) model_mem[i] = '0;
    model_s1 = '0;
    model_s2 = '0;

    phase = "reset";
    cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b1);

    phase = "powerup_read";
    rd(0); rd(1); rd(0); rd(1);

    phase = "single_write";
    wr(0, 16'hBEEF);
    rd(0); rd(0); rd(0);

    phase = "packing";
    wr(0, 16'h1111); wr(1, 16'h2222); wr(2, 16'h3333); wr(3, 16'h4444);
    rd(0); rd(1); rd(0); rd(1);

    phase = "collision";
    wr(0, 16'hBEEF);
    rd(0);
    cycle(1'b1, 1'b1, 0, 16'hCAFE, 1'b1, 0, 1'b0);
    rd(0); rd(0);

    phase = "ena_low";
    cycle(1'b0, 1'b1, 1, 16'hDEAD, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 2, 16'hDEAD, 1'b0, 0, 1'b0);
    rd(0); rd(1); rd(1);

    phase = "enb_hold";
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 0, '0, 1'b0, i % 2, 1'b0);

    phase = "reset_midstream";
    rd(1); rd(1);
    cycle(1'b0, 1'b0, 0, '0, 1'b1, 1, 1'b1);
    phase = "reset_write";
    cycle(1'b1, 1'b1, 2, 16'h5A5A, 1'b1, 0, 1'b1);
    phase = "after_reset";
    rd(1); rd(1); rd(1);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, DEPTH_A - 1)), WIDTH_A'($urandom),
            1'($urandom_range(0, 1)), int'($urandom_range(0, (DEPTH_A / RATIO) - 1)),
            1'($urandom_range(0, 19) == 0));
    end

    phase = "drain";
    cycle(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clka);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
